// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external comparator.
// Optional early completion on equality: define SAR_SEARCH_EARLY_EXIT_EN.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gr,
    input  logic             eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_VERIFY
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_trial;
    logic [KW-1:0]    r_k;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_result;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_trial_nx;
    logic [KW-1:0]    w_k_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_err_nx;
    logic [WIDTH-1:0] w_result_nx;
    logic             w_keep;
    logic [KW-1:0]    w_k_dn;

    // An illegal gr&eq combination simply counts as a keep
    assign w_keep = gr | eq;
    assign w_k_dn = r_k - KW'(1);

    always_comb begin
        w_state_nx  = r_state;
        w_trial_nx  = r_trial;
        w_k_nx      = r_k;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_err_nx    = r_err;
        w_result_nx = r_result;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_trial_nx = MSB_ONLY;
                    w_k_nx     = K_TOP;
                    w_err_nx   = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_TRIAL;
                end
            end
            S_TRIAL: begin
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                if (eq) begin
                    w_result_nx = r_trial;
                    w_err_nx    = 1'b0;
                    w_done_nx   = 1'b1;
                    w_busy_nx   = 1'b0;
                    w_state_nx  = S_IDLE;
                end else
`endif
                begin
                    w_trial_nx[r_k] = w_keep;
                    if (r_k != '0) begin
                        w_trial_nx[w_k_dn] = 1'b1;
                        w_k_nx             = w_k_dn;
                    end else begin
                        w_state_nx = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                w_result_nx = r_trial;
                w_err_nx    = ~eq;
                w_done_nx   = 1'b1;
                w_busy_nx   = 1'b0;
                w_state_nx  = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_trial  <= '0;
            r_k      <= K_TOP;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_trial  <= w_trial_nx;
            r_k      <= w_k_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_result <= w_result_nx;
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator model.
// Expected trial sequences, results and latencies are hand-computed.
module tb_sar_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic       gr;
    logic       eq;
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] result;

    logic [3:0] tgt;
    logic       force_bad;

    int checks;
    int errors;

    sar_search #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .gr     (gr),
        .eq     (eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    assign gr = force_bad ? 1'b0 : (tgt > trial);
    assign eq = force_bad ? 1'b0 : (tgt == trial);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  t;
        bit          bad;
        logic [15:0] tr;
        logic [3:0]  res;
        bit          e;
        int          lat;
        int          lat_ee;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one search; lat/lat_ee < 0 skip the latency check, chk_tr=0 skips trials
    task automatic run(input logic [3:0] t, input bit bad,
                       input logic [15:0] tr, input bit chk_tr,
                       input logic [3:0] res, input bit e,
                       input int lat, input int lat_ee, input bit mid);
        int  n;
        int  nb;
        bit  got;
        int  want;
        @(negedge clk);
        tgt       = t;
        force_bad = bad;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n   = 0;
        nb  = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                if (chk_tr && n < 4)
                    chk($sformatf("trial_T%0d_n%0d", t, n), int'(trial),
                        int'(tr[15-4*n -: 4]));
            end
            if (done) begin
                got = 1;
            end else begin
                start = (mid && (n == 1 || n == 2));
                n++;
            end
        end
        start = 1'b0;
        chk($sformatf("done_seen_T%0d", t), int'(got), 1);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        want = lat_ee;
`else
        want = lat;
        chk($sformatf("busy_cycles_T%0d", t), nb, 5);
`endif
        if (want >= 0)
            chk($sformatf("latency_T%0d", t), n, want);
        chk($sformatf("result_T%0d", t), int'(result), int'(res));
        chk($sformatf("err_T%0d", t), int'(err), int'(e));
        chk($sformatf("busy_at_done_T%0d", t), int'(busy), 0);
        @(negedge clk);
        chk($sformatf("done_pulse_T%0d", t), int'(done), 0);
        force_bad = 1'b0;
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        tgt       = '0;
        force_bad = 1'b0;

        vecs[0] = '{4'd10, 0, 16'h8CAB, 4'd10, 0, 5, 3};
        vecs[1] = '{4'd0,  0, 16'h8421, 4'd0,  0, 5, 5};
        vecs[2] = '{4'd15, 0, 16'h8CEF, 4'd15, 0, 5, 4};
        vecs[3] = '{4'd5,  0, 16'h8465, 4'd5,  0, 5, 4};
        vecs[4] = '{4'd7,  1, 16'h8421, 4'd0,  1, 5, 5};
        vecs[5] = '{4'd8,  0, 16'h8CA9, 4'd8,  0, 5, 1};

        #1;
        chk("rst_trial", int'(trial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run(vecs[i].t, vecs[i].bad, vecs[i].tr, 1'b1, vecs[i].res,
                vecs[i].e, vecs[i].lat, vecs[i].lat_ee, 1'b0);

        // Asynchronous reset in the middle of a search
        @(negedge clk);
        tgt   = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_trial", int'(trial), 10);
        chk("pre_rst_result", int'(result), 8);
        rst = 1'b1;
        #1;
        chk("async_rst_trial", int'(trial), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        run(4'd10, 0, 16'h8CAB, 1'b1, 4'd10, 0, 5, 3, 1'b0);

        // start held high: two back-to-back searches
        @(negedge clk);
        tgt   = 4'd5;
        start = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", int'(done), 1);
        chk("b2b_first_result", int'(result), 5);
        tgt = 4'd9;
        @(negedge clk);
        chk("b2b_busy_restart", int'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b_second_done", int'(done), 1);
        chk("b2b_second_result", int'(result), 9);
        chk("b2b_second_err", int'(err), 0);
        @(negedge clk);

        // start pulses during a search are ignored
        run(4'd10, 0, 16'h8CAB, 1'b1, 4'd10, 0, 5, 3, 1'b1);
        chk("mid_pulse_idle", int'(busy), 0);

        for (int t = 0; t < 16; t++)
            run(4'(t), 0, 16'h0, 1'b0, 4'(t), 0, 5, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
